// File: rtl/tiny_dnn_mac_array.sv
// bfloat16 x bfloat16 dot-product array: F_NUM channels share one streamed input vector and
// accumulate into truncating fp32 (14-bit fraction); results leave over a ready/valid stream.
module tiny_dnn_mac_array #(
  parameter int F_NUM  = 16,
  parameter int F_SIZE = 512,
  parameter int AW     = $clog2(F_SIZE),
  parameter int CW     = (F_NUM > 1) ? $clog2(F_NUM) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_we,
  input  logic [CW-1:0] w_ch,
  input  logic [AW-1:0] w_addr,
  input  logic [15:0]   w_data,
  input  logic [AW:0]   cfg_len,
  input  logic          cfg_relu,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [31:0]   d_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [31:0]   o_data,
  output logic [CW-1:0] o_ch,
  output logic          o_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d, len_q, len_d;
  logic          relu_q, relu_d, drain_q, drain_d, done_q, done_d;
  logic [CW-1:0] och_q, och_d;
  logic          rd_vld_q;
  logic          acc_clr, d_fire;
  logic [15:0]   wrd_q [F_NUM];
  logic [15:0]   d_q;
  logic [31:0]   acc_q [F_NUM];
  logic [31:0]   acc_d [F_NUM];
  logic [15:0]   w_mem [F_NUM][F_SIZE];
  logic [31:0]   res;
  logic          unused_d;

  assign unused_d = ^d_data[15:0];

  // Accumulator value and product share the scale m * 2^(e-141); 8 guard bits sit below both.
  function automatic logic [31:0] mac_step(input logic [22:0] acc_hi, input logic [15:0] w,
                                           input logic [15:0] d);
    logic        p_zero, r_s;
    logic [9:0]  p_e, e_max, diff;
    logic [14:0] a_m;
    logic [15:0] prod;
    logic [31:0] a_al, p_al, sum, mag;
    logic [4:0]  msb;
    logic [10:0] r_e;
    logic [13:0] r_m;
    mac_step = {acc_hi, 9'd0};
    a_m    = (acc_hi[21:14] != 8'd0) ? {1'b1, acc_hi[13:0]} : 15'd0;
    prod   = 16'({1'b1, w[6:0]}) * 16'({1'b1, d[6:0]});
    p_e    = 10'(w[14:7]) + 10'(d[14:7]) - 10'd127;
    p_zero = (w[14:7] == 8'd0) || (d[14:7] == 8'd0) || p_e[9] || (p_e == 10'd0);
    if ({2'b00, acc_hi[21:14]} >= p_e) begin
      e_max = {2'b00, acc_hi[21:14]};
      diff  = e_max - p_e;
    end else begin
      e_max = p_e;
      diff  = p_e - {2'b00, acc_hi[21:14]};
    end
    a_al = {9'd0, a_m, 8'd0};
    p_al = {8'd0, prod, 8'd0};
    if (e_max == p_e) a_al = a_al >> diff;
    else              p_al = p_al >> diff;
    if (acc_hi[22])      a_al = -a_al;
    if (w[15] ^ d[15])   p_al = -p_al;
    sum = a_al + p_al;
    r_s = sum[31];
    mag = r_s ? -sum : sum;
    msb = 5'd0;
    for (int i = 0; i < 25; i++) if (mag[i]) msb = 5'(i);
    r_e = {1'b0, e_max} + 11'(msb) - 11'd22;
    r_m = (msb >= 5'd14) ? 14'(mag >> (msb - 5'd14)) : 14'(mag << (5'd14 - msb));
    if (!p_zero && !(e_max != p_e && diff > 10'd16)) begin
      if (mag == 32'd0 || r_e[10] || r_e == 11'd0) mac_step = 32'd0;
      else                                         mac_step = {r_s, r_e[7:0], r_m, 9'd0};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    relu_d  = relu_q;
    drain_d = drain_q;
    och_d   = och_q;
    done_d  = 1'b0;
    acc_clr = 1'b0;
    d_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        len_d   = cfg_len;
        relu_d  = cfg_relu;
        cnt_d   = '0;
        och_d   = '0;
        acc_clr = 1'b1;
        state_d = (cfg_len == '0) ? OUT : RUN;
      end
      RUN: begin
        d_ready = 1'b1;
        if (d_valid) begin
          cnt_d = cnt_q + (AW+1)'(1);
          if (cnt_q == len_q - (AW+1)'(1)) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = OUT;
      end
      OUT: begin
        o_valid = 1'b1;
        if (o_ready) begin
          if (och_q == CW'(F_NUM - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            och_d   = '0;
          end else begin
            och_d = och_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_fire = d_ready & d_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      drain_q  <= 1'b0;
      och_q    <= '0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      relu_q   <= relu_d;
      drain_q  <= drain_d;
      och_q    <= och_d;
      done_q   <= done_d;
      rd_vld_q <= d_fire;
    end
  end

  // Weight RAM and its read register carry no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_we && state_q == IDLE) w_mem[w_ch][w_addr] <= w_data;
    if (d_fire) begin
      for (int c = 0; c < F_NUM; c++) wrd_q[c] <= w_mem[c][cnt_q[AW-1:0]];
      d_q <= d_data[31:16];
    end
  end

  always_comb begin
    for (int c = 0; c < F_NUM; c++) acc_d[c] = mac_step(acc_q[c][31:9], wrd_q[c], d_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < F_NUM; c++) acc_q[c] <= '0;
    end else if (acc_clr) begin
      for (int c = 0; c < F_NUM; c++) acc_q[c] <= '0;
    end else if (rd_vld_q) begin
      for (int c = 0; c < F_NUM; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign res    = acc_q[och_q];
  assign o_data = (!o_valid || (relu_q && res[31])) ? 32'd0 : res;
  assign o_ch   = och_q;
  assign o_last = o_valid && (och_q == CW'(F_NUM - 1));
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
// Self-checking bench for tiny_dnn_mac_array: directed scenarios plus random integer dot products.
module tb_tiny_dnn_mac_array;
  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;
  localparam int AW     = 9;
  localparam int CW     = 4;

  logic          clk, reset, w_we, cfg_relu, start, busy, done;
  logic          d_valid, d_ready, o_valid, o_ready, o_last;
  logic [CW-1:0] w_ch, o_ch;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic [AW:0]   cfg_len;
  logic [31:0]   d_data, o_data;

  int checks = 0;
  int failures = 0;

  logic [31:0]   got_data [F_NUM];
  logic [CW-1:0] got_ch   [F_NUM];
  logic          got_last [F_NUM];
  logic [31:0]   stall_data [$];
  logic [CW-1:0] stall_ch_q [$];
  logic          stall_last [$];
  logic [31:0]   beat_q [$];
  int            n_out, done_count, dready_cycles;
  logic          done_after, busy_after, busy_at_last;

  tiny_dnn_mac_array #(.F_NUM(F_NUM), .F_SIZE(F_SIZE)) dut (
    .clk(clk), .reset(reset), .w_we(w_we), .w_ch(w_ch), .w_addr(w_addr), .w_data(w_data),
    .cfg_len(cfg_len), .cfg_relu(cfg_relu), .start(start), .busy(busy), .done(done),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ch(o_ch), .o_last(o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] int_to_fp32(input int v);
    int a, p;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (a >= (1 << i)) p = i;
    m = 32'(a) << (23 - p);
    return {v < 0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [15:0] bf16(input int v);
    logic [31:0] f;
    f = int_to_fp32(v);
    return f[31:16];
  endfunction

  task automatic write_w(input int c, input int a, input logic [15:0] v);
    @(negedge clk);
    w_we = 1'b1; w_ch = CW'(c); w_addr = AW'(a); w_data = v;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic load_w(input int n, input logic [15:0] v);
    for (int a = 0; a < n; a++)
      for (int c = 0; c < F_NUM; c++) write_w(c, a, v);
  endtask

  // Runs one job: feeds beat_q, drains outputs, records what it saw for the caller to check.
  task automatic run_job(input int len, input bit relu, input int gap_mode, input int stall_at,
                         input int stall_n, input bit rand_ordy, input bit spoil_w);
    int bi, stall_left, cyc;
    bit rdy, spoiled;
    n_out = 0; done_count = 0; dready_cycles = 0; bi = 0; cyc = 0;
    stall_left = stall_n; spoiled = 1'b0; busy_at_last = 1'b0;
    stall_data.delete(); stall_ch_q.delete(); stall_last.delete();
    @(negedge clk);
    cfg_len = (AW+1)'(len); cfg_relu = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n_out < F_NUM && cyc < 3000) begin
      if (done) done_count++;
      if (d_ready) dready_cycles++;
      w_we = 1'b0;
      if (spoil_w && !spoiled && d_ready) begin
        w_we = 1'b1; w_ch = '0; w_addr = '0; w_data = 16'h0000; d_valid = 1'b0; spoiled = 1'b1;
      end else if (bi < beat_q.size()) begin
        case (gap_mode)
          1:       d_valid = (cyc % 2 == 0);
          2:       d_valid = 1'($urandom_range(0, 1));
          default: d_valid = 1'b1;
        endcase
        d_data = beat_q[bi];
        if (d_valid && d_ready) bi++;
      end else begin
        d_valid = 1'b0;
      end
      rdy = rand_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && stall_at >= 0 && int'(o_ch) == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        stall_data.push_back(o_data); stall_ch_q.push_back(o_ch); stall_last.push_back(o_last);
      end
      o_ready = rdy;
      if (o_valid && rdy) begin
        got_data[n_out] = o_data; got_ch[n_out] = o_ch; got_last[n_out] = o_last;
        busy_at_last = busy;
        n_out++;
      end
      @(negedge clk);
      cyc++;
    end
    o_ready = 1'b0; d_valid = 1'b0; w_we = 1'b0;
    done_after = done; busy_after = busy;
    if (done) done_count++;
    @(negedge clk);
    if (done) done_count++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL reset_o_data got=%h exp=0", o_data); end
    checks++; if (o_ch !== '0 || o_last !== 1'b0) begin
      failures++; $display("FAIL reset_o_ch_last got=%0d/%b exp=0/0", o_ch, o_last);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones();
    load_w(4, 16'h3F80);
    beat_q = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    run_job(4, 1'b0, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL ones_count got=%0d exp=%0d", n_out, F_NUM); end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== 32'h41000000) begin failures++; $display("FAIL ones_data ch%0d got=%h exp=41000000", i, got_data[i]); end
      checks++; if (got_ch[i] !== CW'(i)) begin failures++; $display("FAIL ones_ch idx%0d got=%0d exp=%0d", i, got_ch[i], i); end
      checks++; if (got_last[i] !== (i == F_NUM - 1)) begin failures++; $display("FAIL ones_last idx%0d got=%b", i, got_last[i]); end
    end
    checks++; if (done_count !== 1) begin failures++; $display("FAIL ones_done_pulses got=%0d exp=1", done_count); end
  endtask

  task automatic test_ramp();
    for (int c = 0; c < F_NUM; c++) write_w(c, 0, bf16(c));
    beat_q = '{32'h3F800000};
    run_job(1, 1'b0, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL ramp_count got=%0d exp=%0d", n_out, F_NUM); end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== int_to_fp32(i)) begin failures++; $display("FAIL ramp_data ch%0d got=%h exp=%h", i, got_data[i], int_to_fp32(i)); end
    end
    checks++; if (got_data[0] !== 32'h0 || got_data[3] !== 32'h40400000) begin
      failures++; $display("FAIL ramp_fixed got=%h/%h exp=00000000/40400000", got_data[0], got_data[3]);
    end
    checks++; if (busy_at_last !== 1'b1 || busy_after !== 1'b0) begin
      failures++; $display("FAIL ramp_busy got=%b/%b exp=1/0", busy_at_last, busy_after);
    end
    checks++; if (done_after !== 1'b1) begin failures++; $display("FAIL ramp_done got=%b exp=1", done_after); end
  endtask

  task automatic test_backpressure();
    load_w(4, 16'h3F80);
    beat_q = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    run_job(4, 1'b0, 1, -1, 0, 1'b0, 1'b0);
    checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL gap_count got=%0d exp=%0d", n_out, F_NUM); end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== 32'h41000000) begin failures++; $display("FAIL gap_data ch%0d got=%h exp=41000000", i, got_data[i]); end
    end
    run_job(4, 1'b0, 0, 5, 3, 1'b0, 1'b0);
    checks++; if (stall_data.size() !== 3) begin failures++; $display("FAIL stall_cycles got=%0d exp=3", stall_data.size()); end
    for (int k = 0; k < stall_data.size(); k++) begin
      checks++; if (stall_data[k] !== 32'h41000000 || stall_ch_q[k] !== CW'(5) || stall_last[k] !== 1'b0) begin
        failures++; $display("FAIL stall_hold k%0d got=%h/%0d/%b exp=41000000/5/0", k, stall_data[k], stall_ch_q[k], stall_last[k]);
      end
    end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_ch[i] !== CW'(i) || got_data[i] !== 32'h41000000) begin
        failures++; $display("FAIL stall_seq idx%0d got=%0d/%h exp=%0d/41000000", i, got_ch[i], got_data[i], i);
      end
    end
  endtask

  task automatic test_relu();
    load_w(1, 16'hBF80);
    for (int r = 0; r < 2; r++) begin
      beat_q = '{32'h40400000};
      run_job(1, 1'(r), 0, -1, 0, 1'b0, 1'b0);
      for (int i = 0; i < n_out; i++) begin
        checks++; if (got_data[i] !== ((r == 1) ? 32'h0 : 32'hC0400000)) begin
          failures++; $display("FAIL relu%0d ch%0d got=%h", r, i, got_data[i]);
        end
      end
    end
  endtask

  task automatic test_cancel_and_zero_len();
    load_w(2, 16'h3F80);
    beat_q = '{32'h40A00000, 32'hC0A00000};
    run_job(2, 1'b0, 0, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== 32'h0) begin failures++; $display("FAIL cancel ch%0d got=%h exp=0", i, got_data[i]); end
    end
    beat_q.delete();
    run_job(0, 1'b0, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL zlen_count got=%0d exp=%0d", n_out, F_NUM); end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== 32'h0 || got_ch[i] !== CW'(i)) begin
        failures++; $display("FAIL zlen ch%0d got=%h/%0d exp=0/%0d", i, got_data[i], got_ch[i], i);
      end
    end
    checks++; if (dready_cycles !== 0) begin failures++; $display("FAIL zlen_d_ready got=%0d exp=0", dready_cycles); end
  endtask

  task automatic test_reset_midjob();
    load_w(4, 16'h3F80);
    @(negedge clk);
    cfg_len = (AW+1)'(4); cfg_relu = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; d_valid = 1'b1; d_data = 32'h40000000;
    repeat (2) @(negedge clk);
    d_valid = 1'b0; reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || d_ready !== 1'b0) begin
      failures++; $display("FAIL midreset got busy=%b d_ready=%b exp=0/0", busy, d_ready);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || d_ready !== 1'b0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_hold got=%b/%b/%b exp=0/0/0", busy, d_ready, o_valid);
    end
    reset = 1'b0;
    beat_q = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    run_job(4, 1'b0, 0, -1, 0, 1'b0, 1'b1);
    checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL rerun_count got=%0d exp=%0d", n_out, F_NUM); end
    for (int i = 0; i < n_out; i++) begin
      checks++; if (got_data[i] !== 32'h41000000) begin failures++; $display("FAIL rerun ch%0d got=%h exp=41000000", i, got_data[i]); end
    end
  endtask

  task automatic test_random();
    int wm [F_NUM][8];
    int dv [8];
    int len, sum;
    bit relu;
    logic [31:0] exp_v;
    for (int j = 0; j < 4; j++) begin
      len  = int'($urandom_range(1, 8));
      relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++)
        for (int c = 0; c < F_NUM; c++) begin
          wm[c][i] = int'($urandom_range(0, 14)) - 7;
          write_w(c, i, bf16(wm[c][i]));
        end
      beat_q.delete();
      for (int i = 0; i < len; i++) begin
        dv[i] = int'($urandom_range(0, 14)) - 7;
        beat_q.push_back({bf16(dv[i]), 16'($urandom)});
      end
      run_job(len, relu, 2, -1, 0, 1'b1, 1'b0);
      checks++; if (n_out !== F_NUM) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", j, n_out, F_NUM); end
      for (int c = 0; c < n_out; c++) begin
        sum = 0;
        for (int i = 0; i < len; i++) sum += wm[c][i] * dv[i];
        exp_v = (relu && sum < 0) ? 32'h0 : int_to_fp32(sum);
        checks++; if (got_data[c] !== exp_v || got_ch[c] !== CW'(c)) begin
          failures++; $display("FAIL rand%0d ch%0d got=%h/%0d exp=%h/%0d", j, c, got_data[c], got_ch[c], exp_v, c);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; w_we = 1'b0; w_ch = '0; w_addr = '0; w_data = '0;
    cfg_len = '0; cfg_relu = 1'b0; start = 1'b0;
    d_valid = 1'b0; d_data = '0; o_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ones();
    test_ramp();
    test_backpressure();
    test_relu();
    test_cancel_and_zero_len();
    test_reset_midjob();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_mac_array.md
Name: tiny_dnn_mac_array

Overview:
- Parametrised bfloat16 dot-product engine: F_NUM channels, each holding an F_SIZE-deep weight vector.
- Streams one shared input vector and accumulates W[ch][i]*d[i] in per-channel fp32 accumulators.
- Returns channel results over a ready/valid output stream, with optional ReLU.
- Sits between the host load/command path and the layer sequencer; next-generation MNIST conv/FC kernel.

Parameters:
- F_NUM, 16, channel count (1..64).
- F_SIZE, 512, weight words per channel (power of 2).
- AW, $clog2(F_SIZE), weight address width.
- CW, $clog2(F_NUM) (min 1), channel index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- w_we  in  1  weight write strobe; honoured only in IDLE.
- w_ch  in  CW  weight channel.
- w_addr  in  AW  weight index.
- w_data  in  16  bfloat16 weight.
- cfg_len  in  AW+1  vector length, 0..F_SIZE; sampled at start.
- cfg_relu  in  1  ReLU enable; sampled at start.
- start  in  1  begin job; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on final output handshake.
- d_valid  in  1  input beat valid.
- d_ready  out  1  input beat accepted when d_valid&d_ready.
- d_data  in  32  fp32; bits [31:16] used as bfloat16, [15:0] ignored.
- o_valid  out  1  result valid.
- o_ready  in  1  result accepted.
- o_data  out  32  fp32 result.
- o_ch  out  CW  channel of o_data.
- o_last  out  1  high with channel F_NUM-1.

Behaviour:
- Reset values: busy=0, done=0, d_ready=0, o_valid=0, o_data=0, o_ch=0, o_last=0. State=IDLE, accumulators and counters cleared. Weight RAM is not reset; contents are preserved across reset.
- FSM states: IDLE, RUN, DRAIN, OUT.
  - IDLE -> RUN on start with cfg_len!=0. Accumulators cleared, beat counter=0, cfg latched.
  - IDLE -> OUT on start with cfg_len==0. All results are 0.
  - RUN: d_ready=1. Each accepted beat k reads W[ch][k] for every channel. After beat cfg_len-1 is accepted: d_ready=0 from the next cycle, -> DRAIN. Cycles with d_valid=0 have no effect.
  - DRAIN: exactly 2 cycles, flushing the read-register and accumulate pipeline stages, -> OUT.
  - OUT: channels presented in order 0..F_NUM-1.
    - o_data, o_ch, o_last held stable while o_valid&~o_ready.
    - Advance on handshake.
    - Handshake on channel F_NUM-1 -> IDLE, with done=1 for that following cycle.
- start is ignored outside IDLE. w_we is ignored outside IDLE.
- Pipeline per accepted beat: cycle 1 registers the weight read and d; cycle 2 updates the accumulator. The result is final 2 cycles after the last beat.
- Numerics, identical per channel:
  - Operand with exponent field 0 is treated as zero.
  - Product: 8x8-bit mantissa multiply, exponent ew+ed-127. If ≤0, the product is zero and the accumulator is unchanged.
  - Accumulator is fp32 with a 14-bit kept fraction; bits [8:0] always 0.
  - Alignment: if accumulator exponent exceeds product exponent by >16, the product is discarded. Otherwise shift and add/subtract in 32-bit signed.
  - Normalise with leading-zero count. Truncate toward zero, no rounding. Result exponent ≤0 -> +0.
  - No Inf/NaN handling; overflow behaviour is unspecified.
- ReLU (latched cfg_relu=1): a result with sign=1 is output as 32'h0. Applied at output only.
- Reset asserted mid-job: immediate return to IDLE with outputs at reset values. In-flight input is discarded. A following start works normally with the retained weights.

Test Plan:
1. Load all W=0x3F80 (1.0), cfg_len=4, four beats d=0x40000000 (2.0) -> 16 outputs, each 0x41000000 (8.0); o_ch 0..15; o_last only on ch15; done pulses once.
2. W[c][0]=bf16(c), cfg_len=1, d=0x3F800000 -> o_data=float(c) (ch0=0x00000000, ch3=0x40400000); busy falls the cycle after the last handshake.
3. Backpressure and gaps:
   - d_valid toggling 1/0 during RUN -> same result as scenario 1.
   - o_ready=0 for 3 cycles at ch5 -> o_data/o_ch/o_last unchanged for those cycles, no skipped or duplicated channel.
4. W=0xBF80 (-1.0), cfg_len=1, d=0x40400000 (3.0): relu=0 -> 0xC0400000; relu=1 -> 0x00000000.
5. W=1.0, cfg_len=2, d=5.0 (0x40A00000) then -5.0 (0xC0A00000) -> all outputs 0x00000000. Separately, cfg_len=0 start -> 16 zero outputs, no d_ready.
6. Reset pulse after 2 of 4 beats in scenario 1 -> busy=0, d_ready=0 while reset is high. Rerun scenario 1 without reloading weights -> 0x41000000 per channel. w_we during RUN leaves the weights unchanged.
